// File: rtl/mul_shift_add.sv
// Sequential radix-2 shift-and-add multiplier with a level-held go/done handshake.
// Feeds the modular reducer: P drives its dividend and done drives its go.
module mul_shift_add #(
  parameter int BITS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [BITS-1:0]   A,
  input  logic [BITS-1:0]   B,
  output logic [2*BITS:0]   P,
  output logic              done,
  output logic [7:0]        iters
);

  localparam int PW = 2*BITS + 1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    LOOP = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     a_reg;
  logic [BITS-1:0]   b_reg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Iterations stop as soon as the remaining multiplier bits are all zero.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = go ? LOOP : IDLE;
      LOOP: begin
        if (!go)                state_nxt = IDLE;
        else if (b_reg == '0)   state_nxt = DONE;
        else                    state_nxt = LOOP;
      end
      DONE:    state_nxt = go ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      P     <= '0;
      done  <= 1'b0;
      iters <= '0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            a_reg <= {{(BITS+1){1'b0}}, A};
            b_reg <= B;
            acc   <= '0;
            iters <= '0;
          end
        end
        LOOP: begin
          if (!go) begin
            // An aborted run never exposes a partial product.
            done <= 1'b0;
            P    <= '0;
          end else if (b_reg == '0) begin
            P    <= acc;
            done <= 1'b1;
          end else begin
            if (b_reg[0]) acc <= acc + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            iters <= iters + 8'd1;
          end
        end
        DONE: begin
          if (!go) begin
            done <= 1'b0;
            P    <= '0;
          end
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Bench for mul_shift_add: vector table through a scoreboard, plus reset, abort,
// operand-change and reducer-chaining sequences.
module tb_mul_shift_add;

  localparam int BITS = 64;
  localparam int PW   = 2*BITS + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            go;
  logic [BITS-1:0] A, B;
  logic [PW-1:0]   P;
  logic            done;
  logic [7:0]      iters;

  int checks = 0;
  int errors = 0;

  mul_shift_add #(.BITS(BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .A     (A),
    .B     (B),
    .P     (P),
    .done  (done),
    .iters (iters)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream reducer (modulus 101).
  logic [63:0] r_R;
  logic        r_done;
  int          r_cnt;
  always @(posedge clk) begin
    if (reset || !done) begin
      r_done <= 1'b0;
      r_cnt  <= 0;
    end else if (!r_done) begin
      if (r_cnt == 2) begin
        r_done <= 1'b1;
        r_R    <= 64'(P % 129'd101);
      end else begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [63:0]   a;
    logic [63:0]   b;
    logic [PW-1:0] p;
    int            it;
    int            lat;
    int            hold;
  } vec_t;

  typedef struct {
    logic [PW-1:0] p;
    int            it;
    int            lat;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [PW-1:0] ep, input int eit, input int elat,
                        input int hold, input bit mid_change);
    exp_t e;
    int   cnt;
    e.p = ep; e.it = eit; e.lat = elat;
    sb.push_back(e);
    A  = a;
    B  = b;
    go = 1'b1;
    tick();
    cnt = 0;
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      if (mid_change && cnt == 1) begin
        A = ~A;
        B = ~B;
      end
    end
    chk("done_seen", {128'd0, done}, 129'd1);
    e = sb.pop_front();
    chk("product", P, e.p);
    chk("iters", {121'd0, iters}, PW'(e.it));
    chk("latency", PW'(cnt), PW'(e.lat));
    chk("p_msb", {128'd0, P[PW-1]}, 129'd0);
    for (int i = 0; i < hold; i++) begin
      A = 64'($urandom);
      B = 64'($urandom);
      tick();
      chk("hold_done", {128'd0, done}, 129'd1);
      chk("hold_p", P, e.p);
    end
    go = 1'b0;
    tick();
    chk("release_done", {128'd0, done}, 129'd0);
    chk("release_p", P, 129'd0);
    chk("release_iters", {121'd0, iters}, PW'(e.it));
  endtask

  initial begin
    vecs[0] = '{64'd7, 64'd6, 129'd42, 3, 4, 10};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                129'h0_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64, 65, 0};
    vecs[2] = '{64'h1234, 64'd0, 129'd0, 0, 1, 0};
    vecs[3] = '{64'd0, 64'h8000_0000_0000_0000, 129'd0, 64, 65, 0};
    vecs[4] = '{64'd1, 64'd1, 129'd1, 1, 2, 0};
    vecs[5] = '{64'hDEAD_BEEF, 64'h10, 129'hD_EADB_EEF0, 5, 6, 0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 129'h1_FFFF_FFFF_FFFF_FFFE, 2, 3, 0};
    vecs[7] = '{64'h1_2345_6789, 64'd5, 129'h5_B05B_05AD, 3, 4, 0};

    reset = 1'b1;
    go    = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    chk("reset_p", P, 129'd0);
    chk("reset_done", {128'd0, done}, 129'd0);
    chk("reset_iters", {121'd0, iters}, 129'd0);
    reset = 1'b0;
    tick();

    // Reset lands on the second LOOP edge, then a clean restart.
    A = 64'd5; B = 64'd3; go = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_loop_done", {128'd0, done}, 129'd0);
    chk("rst_loop_p", P, 129'd0);
    chk("rst_loop_iters", {121'd0, iters}, 129'd0);
    run_op(64'd5, 64'd3, 129'd15, 2, 3, 0, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].it, vecs[i].lat, vecs[i].hold, 1'b0);
      tick();
    end

    // Abort after three LOOP edges.
    A = 64'd3; B = 64'hFF; go = 1'b1;
    tick();
    repeat (3) tick();
    go = 1'b0;
    tick();
    chk("abort_done", {128'd0, done}, 129'd0);
    chk("abort_p", P, 129'd0);
    chk("abort_iters", {121'd0, iters}, 129'd3);
    tick();

    // Operands flip during LOOP; product must use the sampled values.
    run_op(64'h11, 64'h0F, 129'hFF, 4, 5, 0, 1'b1);
    tick();

    // Chain into the reducer model.
    A = 64'd100; B = 64'd100; go = 1'b1;
    tick();
    for (int i = 0; i < 200 && !r_done; i++) tick();
    chk("chain_p", P, 129'd10000);
    chk("chain_r_done", {128'd0, r_done}, 129'd1);
    chk("chain_R", {65'd0, r_R}, 129'd1);
    go = 1'b0;
    tick();
    chk("chain_mul_done_clr", {128'd0, done}, 129'd0);
    tick();
    chk("chain_red_done_clr", {128'd0, r_done}, 129'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
